// File: rtl/iddmm_result_rd.sv
// ---------------------------------------------------------------------------
// iddmm_result_rd
//
// Result drain stage for the IDDMM Montgomery multiplier. For each
// operation both result FIFOs (raw words and result-minus-modulus words)
// are popped in lock-step. One word of each popped pair is kept, chosen by
// the final-compare sign latched at cal_done. The kept words are presented
// LSW-first on an output stream. The other word is discarded, so both FIFOs
// are empty when the operation ends.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   cal_done/cal_sign start pulse + stream select (1 = subtracted words)
//   fifo_empty_a      raw FIFO empty; fifo_rd_en_a pops it; data 1 cycle later
//   fifo_empty_sub    subtracted FIFO empty; fifo_rd_en_sub pops it
//   o_valid/o_ready   output handshake
//   o_data/o_idx      output word and its index (0 = LSW)
//   o_last            o_data is word N-1
//   o_done            one-cycle pulse after the last word is accepted
//   o_err             one-cycle pulse: cal_done seen while draining
//   busy              high while draining (this is also the FSM state)
//
// Handshake: a word moves when o_valid & o_ready at a rising clk edge.
// While o_valid is high and o_ready is low, o_data, o_idx and o_last
// hold their values.
// ---------------------------------------------------------------------------
module iddmm_result_rd #(
  parameter int K      = 256,
  parameter int N      = 16,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cal_done,
  input  logic              cal_sign,
  input  logic              fifo_empty_a,
  output logic              fifo_rd_en_a,
  input  logic [K-1:0]      fifo_rd_data_a,
  input  logic              fifo_empty_sub,
  output logic              fifo_rd_en_sub,
  input  logic [K-1:0]      fifo_rd_data_sub,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [K-1:0]      o_data,
  output logic [ADDR_W-1:0] o_idx,
  output logic              o_last,
  output logic              o_done,
  output logic              o_err,
  output logic              busy
);

  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t state, state_nx;

  logic              sel;       // 1 = keep subtracted words
  logic [CNT_W-1:0]  pop_cnt;   // pairs popped this operation (0..N)
  logic [ADDR_W-1:0] out_cnt;   // words accepted this operation
  logic              inflight;  // a pop was issued last cycle; data arrives now
  logic [K-1:0]      buf0;      // skid buffer head (drives o_data)
  logic [K-1:0]      buf1;      // skid buffer second entry
  logic [1:0]        occ;       // skid buffer occupancy (0..2)

  logic              fire;
  logic              last_fire;
  logic              start;
  logic              credit_ok;
  logic              pop;
  logic [K-1:0]      new_word;

  assign fire      = o_valid & o_ready;
  assign last_fire = fire & (out_cnt == ADDR_W'(N - 1));
  assign start     = (state == IDLE) & cal_done;
  assign new_word  = sel ? fifo_rd_data_sub : fifo_rd_data_a;

  // The skid buffer has two entries. A pop issued now lands two edges later,
  // so count buffered words plus the in-flight pop, less the word leaving
  // this cycle, and allow another pop only if that total is below 2.
  assign credit_ok = ({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, fire});

  // One shared pop for both FIFOs; a single FIFO is never popped alone.
  assign pop = (state == DRAIN) & ~fifo_empty_a & ~fifo_empty_sub &
               (pop_cnt < CNT_W'(N)) & credit_ok;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // FSM: next state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (cal_done)  state_nx = DRAIN;
      DRAIN:   if (last_fire) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    fifo_rd_en_a   = pop;
    fifo_rd_en_sub = pop;
    busy           = (state == DRAIN);
  end

  // -------------------------------------------------------------------------
  // Counters, select latch, status pulses
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel      <= 1'b0;
      pop_cnt  <= '0;
      out_cnt  <= '0;
      inflight <= 1'b0;
      o_done   <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      o_done   <= last_fire;
      // A second cal_done during a drain is reported and otherwise ignored.
      o_err    <= cal_done & (state == DRAIN);
      inflight <= pop;
      if (start) begin
        sel     <= cal_sign;
        pop_cnt <= '0;
        out_cnt <= '0;
      end else begin
        if (pop)  pop_cnt <= pop_cnt + CNT_W'(1);
        if (fire) out_cnt <= out_cnt + ADDR_W'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Two-entry skid buffer. The head (buf0) is the output register, so
  // o_data never has a combinational path from the FIFO read data.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf0 <= '0;
      buf1 <= '0;
      occ  <= 2'd0;
    end else begin
      case ({inflight, fire})
        2'b10: begin
          if (occ == 2'd0) buf0 <= new_word;
          else             buf1 <= new_word;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          buf0 <= buf1;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged; the new word goes in behind the head.
          if (occ == 2'd1) begin
            buf0 <= new_word;
          end else begin
            buf0 <= buf1;
            buf1 <= new_word;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_valid = (occ != 2'd0);
  assign o_data  = buf0;
  assign o_idx   = out_cnt;
  assign o_last  = o_valid & (out_cnt == ADDR_W'(N - 1));

endmodule
